// File: rtl/sysarr_load_sequencer.sv
// Memory-side load sequencer: fetches weight, input and partial-sum rows for one
// GEMM from a single-port row memory and streams them to the array FIFOs.
module sysarr_load_sequencer #(
   parameter int N  = 4,
   parameter int DW = 16,
   parameter int AW = 16
) (
   input  logic                         clk,
   input  logic                         RST,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_load_w,
   input  logic [AW-1:0]                cmd_w_base,
   input  logic [AW-1:0]                cmd_in_base,
   input  logic [AW-1:0]                cmd_ps_base,
   input  logic                         fifo_has_space,
   output logic                         mem_req,
   output logic [AW-1:0]                mem_addr,
   input  logic                         mem_rvalid,
   input  logic [N*DW-1:0]              mem_rdata,
   output logic                         weight_en,
   output logic                         input_en,
   output logic [(N>1?$clog2(N):1)-1:0] row_in_en,
   output logic [N*DW-1:0]              in_data,
   output logic                         partial_en,
   output logic [(N>1?$clog2(N):1)-1:0] row_ps_en,
   output logic [N*DW-1:0]              ps_data,
   output logic                         busy,
   output logic                         gemm_done
);

   localparam int RW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {IDLE, WAIT_SPACE, WGT, INP, PS, DONE} state_t;

   state_t        state;
   state_t        next_phase;
   logic [RW-1:0] row;
   logic          load_w;
   logic [AW-1:0] w_base;
   logic [AW-1:0] in_base;
   logic [AW-1:0] ps_base;
   logic [AW-1:0] phase_base;

   always_comb begin
      phase_base = in_base;
      next_phase = PS;
      case (state)
         WGT:     begin phase_base = w_base;  next_phase = INP;  end
         INP:     begin phase_base = in_base; next_phase = PS;   end
         PS:      begin phase_base = ps_base; next_phase = DONE; end
         default: begin phase_base = in_base; next_phase = PS;   end
      endcase
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         row        <= '0;
         load_w     <= 1'b0;
         w_base     <= '0;
         in_base    <= '0;
         ps_base    <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         weight_en  <= 1'b0;
         input_en   <= 1'b0;
         partial_en <= 1'b0;
         row_in_en  <= '0;
         row_ps_en  <= '0;
         in_data    <= '0;
         ps_data    <= '0;
         gemm_done  <= 1'b0;
      end else begin
         // Enables and row indices are single-cycle; data buses keep their last row.
         weight_en  <= 1'b0;
         input_en   <= 1'b0;
         partial_en <= 1'b0;
         row_in_en  <= '0;
         row_ps_en  <= '0;
         gemm_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  load_w  <= cmd_load_w;
                  w_base  <= cmd_w_base;
                  in_base <= cmd_in_base;
                  ps_base <= cmd_ps_base;
                  row     <= '0;
                  state   <= WAIT_SPACE;
               end
            end
            WAIT_SPACE: begin
               if (fifo_has_space) state <= load_w ? WGT : INP;
            end
            WGT, INP, PS: begin
               if (!mem_req) begin
                  // One outstanding read; the address stays put until the response.
                  mem_req  <= 1'b1;
                  mem_addr <= phase_base + AW'(row);
               end else if (mem_rvalid) begin
                  mem_req <= 1'b0;
                  if (state == PS) begin
                     partial_en <= 1'b1;
                     row_ps_en  <= row;
                     ps_data    <= mem_rdata;
                  end else begin
                     weight_en <= (state == WGT);
                     input_en  <= (state == INP);
                     row_in_en <= row;
                     in_data   <= mem_rdata;
                  end
                  if (row == RW'(N - 1)) begin
                     row   <= '0;
                     state <= next_phase;
                     if (state == PS) gemm_done <= 1'b1;
                  end else begin
                     row <= row + 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sysarr_load_sequencer.sv
// Bench for sysarr_load_sequencer: memory model with programmable latency and a
// scoreboard of expected row deliveries and read addresses.
module tb_sysarr_load_sequencer;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int AW  = 16;
   localparam int RW  = 2;
   localparam int RDW = N * DW;

   logic           clk = 1'b0;
   logic           rst;
   logic           cmd_valid, cmd_ready, cmd_load_w;
   logic [AW-1:0]  cmd_w_base, cmd_in_base, cmd_ps_base;
   logic           fifo_has_space;
   logic           mem_req, mem_rvalid;
   logic [AW-1:0]  mem_addr;
   logic [RDW-1:0] mem_rdata, in_data, ps_data;
   logic           weight_en, input_en, partial_en, busy, gemm_done;
   logic [RW-1:0]  row_in_en, row_ps_en;

   logic [2+RW+RDW-1:0] exp_q[$];
   logic [AW-1:0]       exp_addr_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_en    = 0;
   int n_inp   = 0;
   int n_done  = 0;
   int lat_mode = 1;
   int spur_req = 0;
   int spur_done = 0;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, %0d run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   sysarr_load_sequencer #(.N(N), .DW(DW), .AW(AW)) dut (
      .clk(clk), .RST(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load_w(cmd_load_w),
      .cmd_w_base(cmd_w_base), .cmd_in_base(cmd_in_base), .cmd_ps_base(cmd_ps_base),
      .fifo_has_space(fifo_has_space),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .weight_en(weight_en), .input_en(input_en), .row_in_en(row_in_en), .in_data(in_data),
      .partial_en(partial_en), .row_ps_en(row_ps_en), .ps_data(ps_data),
      .busy(busy), .gemm_done(gemm_done)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [RDW-1:0] row_data(input logic [AW-1:0] a);
      return {a ^ 16'hA5A5, a + 16'd1, ~a, a ^ 16'h0F0F};
   endfunction

   function automatic void push_exp(input logic lw, input logic [AW-1:0] wb, ib, pb);
      logic [AW-1:0] a;
      for (int ph = 0; ph < 3; ph++) begin
         if (ph == 0 && !lw) continue;
         for (int r = 0; r < N; r++) begin
            a = (ph == 0 ? wb : (ph == 1 ? ib : pb)) + AW'(r);
            exp_addr_q.push_back(a);
            exp_q.push_back({2'(ph + 1), RW'(r), row_data(a)});
         end
      end
   endfunction

   // monitor + memory model, both sampling on the falling edge
   initial begin : bus
      logic [2+RW+RDW-1:0] got_e;
      logic [1:0]          kind;
      logic [AW-1:0]       cur_addr;
      logic                in_req;
      int                  wait_left;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      in_req     = 1'b0;
      cur_addr   = '0;
      wait_left  = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (!(weight_en || input_en)) check_eq("row_in_idle", row_in_en, 0);
            if (!partial_en) check_eq("row_ps_idle", row_ps_en, 0);
            if (weight_en || input_en || partial_en) begin
               check_eq("en_onehot", $onehot({weight_en, input_en, partial_en}), 1);
               n_en++;
               if (input_en) n_inp++;
               kind  = weight_en ? 2'd1 : (input_en ? 2'd2 : 2'd3);
               got_e = (weight_en || input_en) ? {kind, row_in_en, in_data}
                                               : {kind, row_ps_en, ps_data};
               if (exp_q.size() == 0) check_eq("unexpected_en", got_e, 0);
               else check_eq("row", got_e, exp_q.pop_front());
            end
            if (gemm_done) begin
               n_done++;
               check_eq("done_rows_left", exp_q.size(), 0);
            end
         end
         if (mem_rvalid || rst) begin
            mem_rvalid = 1'b0;
            in_req     = 1'b0;
         end else if (spur_req != spur_done) begin
            mem_rvalid = 1'b1;
            mem_rdata  = '1;
            spur_done++;
         end else if (mem_req) begin
            if (!in_req) begin
               in_req   = 1'b1;
               cur_addr = mem_addr;
               if (exp_addr_q.size() == 0) check_eq("unexpected_req", mem_req, 0);
               else check_eq("addr", mem_addr, exp_addr_q.pop_front());
               if (lat_mode < 0) begin
                  case ($urandom_range(0, 2))
                     0:       wait_left = 0;
                     1:       wait_left = 1;
                     default: wait_left = 5;
                  endcase
               end else begin
                  wait_left = lat_mode;
               end
            end else begin
               check_eq("addr_stable", mem_addr, cur_addr);
            end
            if (wait_left == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = row_data(cur_addr);
               in_req     = 1'b0;
            end else begin
               wait_left--;
            end
         end
      end
   end

   // drivers
   task automatic send(input logic lw, input logic [AW-1:0] wb, ib, pb);
      push_exp(lw, wb, ib, pb);
      cmd_load_w  = lw;
      cmd_w_base  = wb;
      cmd_in_base = ib;
      cmd_ps_base = pb;
      cmd_valid   = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (cmd_ready) break;
         @(negedge clk);
      end
      if (!cmd_ready) check_eq("cmd_ready_timeout", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (gemm_done) break;
      end
      if (!gemm_done) check_eq("done_timeout", gemm_done, 1);
   endtask

   task automatic run_gemm(input logic lw, input logic [AW-1:0] wb, ib, pb);
      int e0, d0;
      e0 = n_en;
      d0 = n_done;
      send(lw, wb, ib, pb);
      wait_done();
      @(negedge clk);
      #1;
      check_eq("done_pulse", gemm_done, 0);
      check_eq("en_count", n_en - e0, lw ? 12 : 8);
      check_eq("done_count", n_done - d0, 1);
      check_eq("addr_left", exp_addr_q.size(), 0);
      check_eq("idle_after", {cmd_ready, busy}, 2'b10);
   endtask

   initial begin : main
      int e0, n0;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_load_w = 1'b0;
      cmd_w_base = '0;
      cmd_in_base = '0;
      cmd_ps_base = '0;
      fifo_has_space = 1'b1;

      @(negedge clk);
      check_eq("rst_outs", {weight_en, input_en, partial_en, mem_req, busy, gemm_done,
                            row_in_en, row_ps_en}, 0);
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_buses", {mem_addr, in_data, ps_data}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // full GEMM with weight reload, latency 1
      lat_mode = 1;
      run_gemm(1'b1, 16'h0010, 16'h0020, 16'h0030);

      // no weight reload
      run_gemm(1'b0, 16'h0010, 16'h0020, 16'h0030);

      // fifo_has_space low for 10 cycles after the command
      fifo_has_space = 1'b0;
      e0 = n_en;
      send(1'b1, 16'h1000, 16'h2000, 16'h3000);
      for (int k = 0; k < 10; k++) begin
         check_eq("wait_space_req", {mem_req, busy}, 2'b01);
         @(negedge clk);
      end
      fifo_has_space = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (mem_req) break;
      end
      check_eq("req_after_space", mem_req, 1);
      wait_done();
      #1;
      check_eq("space_en_count", n_en - e0, 12);

      // variable latency (0, 1 or 5 wait cycles per row)
      lat_mode = -1;
      run_gemm(1'b1, 16'(($urandom_range(0, 65535))), 16'h4000, 16'(($urandom_range(0, 65535))));
      for (int g = 0; g < 2; g++)
         run_gemm(1'($urandom_range(0, 1)), 16'(($urandom_range(0, 65535))),
                  16'(($urandom_range(0, 65535))), 16'(($urandom_range(0, 65535))));

      // address wrap, then a command held through DONE
      lat_mode = 0;
      send(1'b0, 16'h0100, 16'hFFFE, 16'h0200);
      wait_done();
      push_exp(1'b1, 16'h0300, 16'h0400, 16'h0500);
      cmd_load_w  = 1'b1;
      cmd_w_base  = 16'h0300;
      cmd_in_base = 16'h0400;
      cmd_ps_base = 16'h0500;
      cmd_valid   = 1'b1;
      check_eq("ready_in_done", cmd_ready, 0);
      @(negedge clk);
      check_eq("idle_after_done", {cmd_ready, busy}, 2'b10);
      @(negedge clk);
      check_eq("held_cmd_taken", {cmd_ready, busy}, 2'b01);
      cmd_valid = 1'b0;
      wait_done();
      #1;
      check_eq("held_addr_left", exp_addr_q.size(), 0);

      // reset while input row 2 is outstanding
      lat_mode = 2;
      n0 = n_inp;
      send(1'b0, 16'h0040, 16'h0050, 16'h0060);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (n_inp - n0 >= 2 && mem_req) break;
      end
      check_eq("reached_inp2", {mem_req, mem_addr}, {1'b1, 16'h0052});
      rst = 1'b1;
      #1;
      check_eq("midrst_outs", {weight_en, input_en, partial_en, mem_req, busy, gemm_done,
                               row_in_en, row_ps_en}, 0);
      check_eq("midrst_ready", cmd_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
      @(negedge clk);
      e0 = n_en;
      spur_req++;
      repeat (4) @(negedge clk);
      #1;
      check_eq("late_rvalid_ignored", n_en - e0, 0);
      check_eq("late_rvalid_state", {cmd_ready, busy, mem_req}, 3'b100);

      // recovery after reset
      lat_mode = 1;
      run_gemm(1'b1, 16'h0070, 16'h0080, 16'h0090);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sysarr_load_sequencer.md
Name: sysarr_load_sequencer

Overview:
- Memory-side producer for the systolic array control unit's load interface.
- Accepts one GEMM command, fetches rows from a single-port row memory, and streams them into the array FIFOs using the control unit's row-enable protocol:
  - optional N weight rows
  - N input rows
  - N partial-sum rows
- Gates every new GEMM on `fifo_has_space`. Weights and inputs share the input bus and are never enabled together.

Parameters:
- N, 4, array dimension; rows per matrix.
- DW, 16, element width in bits.
- AW, 16, row-address width.

Ports:
- clk  input  1  clock
- RST  input  1  asynchronous active-high reset
- cmd_valid  input  1  GEMM command valid
- cmd_ready  output  1  sequencer can accept a command
- cmd_load_w  input  1  reload weights before inputs
- cmd_w_base  input  AW  weight matrix base row address
- cmd_in_base  input  AW  input matrix base row address
- cmd_ps_base  input  AW  partial-sum matrix base row address
- fifo_has_space  input  1  control unit can accept a new GEMM's rows
- mem_req  output  1  row read request, held until mem_rvalid
- mem_addr  output  AW  row address
- mem_rvalid  input  1  read data valid; one per request
- mem_rdata  input  N*DW  row data
- weight_en  output  1  weight row present on in_data
- input_en  output  1  input row present on in_data
- row_in_en  output  $clog2(N)  row index for weight/input row
- in_data  output  N*DW  weight/input row data
- partial_en  output  1  partial row present on ps_data
- row_ps_en  output  $clog2(N)  partial row index
- ps_data  output  N*DW  partial row data
- busy  output  1  FSM not in IDLE
- gemm_done  output  1  one-cycle pulse after last partial row is delivered

Behaviour:

Reset (asynchronous, RST=1):
- FSM → IDLE; row counter cleared; command registers cleared.
- All outputs 0, except cmd_ready=1.
- Reset mid-operation abandons the GEMM. A late mem_rvalid after reset is ignored.

FSM states: IDLE, WAIT_SPACE, WGT, INP, PS, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch the three bases and cmd_load_w, clear the row counter, then go to WAIT_SPACE. cmd_ready=0 in every other state.
- WAIT_SPACE: stay until fifo_has_space=1, sampled at the clock edge. Then go to WGT if cmd_load_w=1, otherwise INP. No mem_req is issued in this state.
- WGT / INP / PS: each fetches rows 0..N-1 in order, one outstanding request at a time.
  - mem_addr = latched base + row; AW-bit add, wrap-around permitted.
  - mem_req rises the cycle after state entry or after the previous delivery. It holds with a stable address until mem_rvalid=1.
  - mem_rvalid while mem_req=0 is ignored.
- Row delivery (mem_rvalid sampled high at edge t):
  - At t+1, exactly one of weight_en / input_en / partial_en is high for one cycle (matching the state).
  - The matching row index and data are registered alongside it.
  - Data buses hold their last value otherwise; enables are 0.
- Phase ends on delivery of row N-1: the counter wraps to 0 and the state advances WGT→INP→PS→DONE.
- Back-to-back rows: the minimum spacing between enables is 2 cycles (request, then response).
- DONE: gemm_done=1 for one cycle, then IDLE. A command arriving during DONE is not accepted; cmd_ready rises in IDLE.

Invariants:
- weight_en and input_en are never both high.
- partial_en is never high with either of them. Phases are serialized.
- row_in_en and row_ps_en are 0 whenever their enable is 0.

Additional rules:
- fifo_has_space is checked only in WAIT_SPACE. Deassertion mid-phase does not stall the sequencer; the control unit's pipelining absorbs the remaining rows.
- busy = (state != IDLE).

Test Plan:
1. Reset: assert RST mid-INP at row 2 → next cycle all enables 0, mem_req=0, cmd_ready=1, busy=0. Then inject mem_rvalid=1 → no enable pulse.
2. cmd_load_w=1, bases 0x10/0x20/0x30, fifo_has_space=1, memory latency 1:
   - mem_addr sequence 0x10..0x13, 0x20..0x23, 0x30..0x33.
   - weight_en rows 0-3, then input_en rows 0-3, then partial_en rows 0-3, each carrying matching data.
   - gemm_done pulses once after partial row 3.
3. cmd_load_w=0 → no weight_en and no 0x10-range address. First enable is input_en with row_in_en=0.
4. fifo_has_space held 0 for 10 cycles after command → no mem_req during those cycles. First mem_req appears the cycle after fifo_has_space=1 is sampled.
5. Variable memory latency (1, 5, 0-gap mem_rvalid stalls):
   - mem_addr is stable while mem_req is high.
   - Exactly 12 enable pulses occur.
   - Rows are in order, and weight_en/input_en are never concurrent.
6. cmd_in_base=0xFFFE → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. A second cmd_valid held during DONE is accepted only in the following IDLE cycle.
